// File: rtl/sr04_pkg.sv
// Shared types and derived timing constants for the HC-SR04 ranging controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sr04_pkg;

  // Ranging sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIG      = 2'd1,
    WAIT_ECHO = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  // Nominal board clock and trigger width
  localparam int unsigned CLK_HZ_NOM  = 100_000_000;
  localparam int unsigned TRIG_US_NOM = 10;

  // System clock cycles per microsecond
  function automatic int unsigned cyc_per_us(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // Trigger pulse length in system clock cycles
  function automatic int unsigned trig_cycles(input int unsigned clk_hz,
                                              input int unsigned trig_us);
    return trig_us * cyc_per_us(clk_hz);
  endfunction

endpackage

// File: rtl/sr04_btn_debounce.sv
// Button debouncer: 2-FF sync, sampled at DB_TICK_HZ, level accepted after DB_SAMPLES equal samples.
// Latency: 2 sync cycles + DB_SAMPLES sample ticks + 1 cycle to the registered press pulse.
// Backpressure: none; emits a single-cycle pulse on each accepted rising level.
module sr04_btn_debounce #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned DB_TICK_HZ = 100_000,
  parameter int unsigned DB_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_btn
);

  localparam int unsigned TDIV  = CLK_HZ / DB_TICK_HZ;
  localparam int unsigned TD_W  = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int unsigned CNT_W = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;

  logic             r_s1;
  logic             r_s2;
  logic [TD_W-1:0]  r_tdiv;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_tick;
  logic             w_accept;

  assign w_tick   = (r_tdiv == TD_W'(TDIV - 1));
  // Last of DB_SAMPLES consecutive samples disagreeing with the accepted level
  assign w_accept = w_tick && (r_s2 != r_level) && (r_cnt == CNT_W'(DB_SAMPLES - 1));

  // Two-flop synchronizer for the raw button
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Free-running sample-rate divider
  always_ff @(posedge clk) begin
    if (!rst || w_tick) begin
      r_tdiv <= '0;
    end else begin
      r_tdiv <= r_tdiv + TD_W'(1);
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the run
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_tick) begin
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // One-cycle pulse when the accepted level goes high
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_btn <= 1'b0;
    end else begin
      o_btn <= w_accept & r_s2;
    end
  end

endmodule

// File: rtl/sr04_controller.sv
// HC-SR04 ranging controller: press -> 10 us trigger -> time echo -> distance in cm (build option SR04_DEBOUNCE_EN adds the button debouncer).
// Latency: start 3 cycles after btn_r rise (70-90 us with debouncer); distance updates the cycle after the synced echo fall.
// Backpressure: none; start requests outside IDLE and echo edges outside WAIT_ECHO/MEASURE are dropped.
module sr04_controller
  import sr04_pkg::*;
#(
  parameter int unsigned CLK_HZ       = CLK_HZ_NOM,
  parameter int unsigned TRIG_US      = TRIG_US_NOM,
  parameter int unsigned US_PER_CM    = 58,
  parameter int unsigned DIST_MAX     = 400,
  parameter int unsigned ECHO_WAIT_US = 100_000,
  parameter int unsigned ECHO_MAX_US  = 30_000
`ifdef SR04_DEBOUNCE_EN
  ,
  parameter int unsigned DB_TICK_HZ   = 100_000,
  parameter int unsigned DB_SAMPLES   = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_r,
  input  logic       echo,
  output logic       o_trigger,
  output logic [8:0] distance
);

  localparam int unsigned CPU      = cyc_per_us(CLK_HZ);
  localparam int unsigned TRIG_CYC = trig_cycles(CLK_HZ, TRIG_US);
  localparam int unsigned DIV_W    = (CPU > 1) ? $clog2(CPU) : 1;
  localparam int unsigned TRG_W    = (TRIG_CYC > 1) ? $clog2(TRIG_CYC) : 1;
  localparam int unsigned US_LIM   = (ECHO_WAIT_US > ECHO_MAX_US) ? ECHO_WAIT_US : ECHO_MAX_US;
  localparam int unsigned US_W     = $clog2(US_LIM + 1);
  localparam int unsigned SUB_W    = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_echo_s1;
  logic             r_echo_s2;
  logic             r_echo_d;
  logic [DIV_W-1:0] r_div;
  logic [TRG_W-1:0] r_trig_cnt;
  logic [US_W-1:0]  r_us_cnt;
  logic [SUB_W-1:0] r_sub_cnt;
  logic [8:0]       r_cm;
  logic [8:0]       w_cm_nxt;
  logic             w_start;
  logic             w_state_chg;
  logic             w_tick;
  logic             w_echo_rise;
  logic             w_echo_fall;
  logic             w_trig_done;
  logic             w_wait_to;
  logic             w_meas_to;
  logic             w_sub_wrap;
  logic             w_cm_inc;
  logic             w_trig_nxt;
  logic             w_dist_ld;
  logic             w_dist_sat;

`ifdef SR04_DEBOUNCE_EN
  sr04_btn_debounce #(
    .CLK_HZ     (CLK_HZ),
    .DB_TICK_HZ (DB_TICK_HZ),
    .DB_SAMPLES (DB_SAMPLES)
  ) u_btn_db (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_r),
    .o_btn (w_start)
  );
`else
  logic r_btn_s1;
  logic r_btn_s2;
  logic r_btn_d;

  // Synchronize the button and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_btn_d  <= 1'b0;
    end else begin
      r_btn_s1 <= btn_r;
      r_btn_s2 <= r_btn_s1;
      r_btn_d  <= r_btn_s2;
    end
  end

  assign w_start = r_btn_s2 & ~r_btn_d;
`endif

  assign w_state_chg = (w_state_nxt != r_state);
  assign w_tick      = (r_div == DIV_W'(CPU - 1));
  assign w_echo_rise = r_echo_s2 & ~r_echo_d;
  assign w_echo_fall = ~r_echo_s2 & r_echo_d;
  assign w_trig_done = (r_trig_cnt == TRG_W'(TRIG_CYC - 1));
  assign w_wait_to   = (r_state == WAIT_ECHO) && w_tick && (r_us_cnt == US_W'(ECHO_WAIT_US - 1));
  assign w_meas_to   = (r_state == MEASURE) && w_tick && (r_us_cnt == US_W'(ECHO_MAX_US - 1));
  assign w_sub_wrap  = (r_state == MEASURE) && w_tick && (r_sub_cnt == SUB_W'(US_PER_CM - 1));
  assign w_cm_inc    = w_sub_wrap && (r_cm < 9'(DIST_MAX));

  // Echo synchronizer plus one delay stage for rise/fall detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_d  <= 1'b0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
    end
  end

  // 1 MHz tick prescaler, realigned on every state change so intervals start clean
  always_ff @(posedge clk) begin
    if (!rst || w_state_chg || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Trigger width counter, runs only while in TRIG
  always_ff @(posedge clk) begin
    if (!rst || w_state_chg || (r_state != TRIG)) begin
      r_trig_cnt <= '0;
    end else begin
      r_trig_cnt <= r_trig_cnt + TRG_W'(1);
    end
  end

  // Elapsed microseconds in WAIT_ECHO / MEASURE for the timeouts
  always_ff @(posedge clk) begin
    if (!rst || w_state_chg) begin
      r_us_cnt <= '0;
    end else if (w_tick && ((r_state == WAIT_ECHO) || (r_state == MEASURE))) begin
      r_us_cnt <= r_us_cnt + US_W'(1);
    end
  end

  // Microseconds within the current centimetre
  always_ff @(posedge clk) begin
    if (!rst || w_state_chg) begin
      r_sub_cnt <= '0;
    end else if (w_tick && (r_state == MEASURE)) begin
      r_sub_cnt <= w_sub_wrap ? '0 : r_sub_cnt + SUB_W'(1);
    end
  end

  // Centimetre count including this cycle's increment, so a fall on a tick edge is not lost
  always_comb begin
    w_cm_nxt = r_cm;
    if (w_cm_inc) begin
      w_cm_nxt = r_cm + 9'd1;
    end
  end

  // Saturating centimetre counter
  always_ff @(posedge clk) begin
    if (!rst || w_state_chg) begin
      r_cm <= '0;
    end else begin
      r_cm <= w_cm_nxt;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; echo fall wins over the MEASURE timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_start) w_state_nxt = TRIG;
      TRIG:      if (w_trig_done) w_state_nxt = WAIT_ECHO;
      WAIT_ECHO: begin
        if (w_echo_rise)    w_state_nxt = MEASURE;
        else if (w_wait_to) w_state_nxt = IDLE;
      end
      MEASURE:   if (w_echo_fall || w_meas_to) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: trigger level and distance-load strobes
  always_comb begin
    w_trig_nxt = (w_state_nxt == TRIG);
    w_dist_ld  = (r_state == MEASURE) && w_echo_fall;
    w_dist_sat = (r_state == MEASURE) && !w_echo_fall && w_meas_to;
  end

  // Registered sensor trigger and distance result
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_trigger <= 1'b0;
      distance  <= '0;
    end else begin
      o_trigger <= w_trig_nxt;
      if (w_dist_ld) begin
        distance <= w_cm_nxt;
      end else if (w_dist_sat) begin
        distance <= 9'(DIST_MAX);
      end
    end
  end

endmodule

// File: tb/tb_sr04_controller.sv
// Self-checking bench for sr04_controller at a scaled 2 MHz clock (2 cycles per us).
// Latency: n/a.
// Backpressure: n/a.
module tb_sr04_controller;

  localparam int CLK_HZ       = 2_000_000;
  localparam int CPU          = 2;
  localparam int TRIG_US      = 10;
  localparam int US_PER_CM    = 58;
  localparam int DIST_MAX     = 12;
  localparam int ECHO_WAIT_US = 2000;
  localparam int ECHO_MAX_US  = 800;
  localparam int TRIG_CYC     = TRIG_US * CPU;
`ifdef SR04_DEBOUNCE_EN
  localparam int LAT_MIN      = 140;
  localparam int LAT_MAX      = 180;
`else
  localparam int LAT_MIN      = 3;
  localparam int LAT_MAX      = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_r;
  logic       echo;
  logic       o_trigger;
  logic [8:0] distance;

  int n_chk  = 0;
  int n_err  = 0;
  int n_trig = 0;
  int tw     = 0;
  int last_dist = 0;
  int q_trig[$];
  int q_dist[$];

  sr04_controller #(
    .CLK_HZ       (CLK_HZ),
    .TRIG_US      (TRIG_US),
    .US_PER_CM    (US_PER_CM),
    .DIST_MAX     (DIST_MAX),
    .ECHO_WAIT_US (ECHO_WAIT_US),
    .ECHO_MAX_US  (ECHO_MAX_US)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_r     (btn_r),
    .echo      (echo),
    .o_trigger (o_trigger),
    .distance  (distance)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: floor division, saturation, and abort on over-long echo
  function automatic int exp_cm(input int us);
    int r;
    if (us > ECHO_MAX_US) return DIST_MAX;
    r = us / US_PER_CM;
    return (r > DIST_MAX) ? DIST_MAX : r;
  endfunction

  // Trigger pulse monitor: each completed pulse is checked against the expected-width queue
  always @(negedge clk) begin
    if (o_trigger === 1'b1) begin
      tw++;
    end else if (tw != 0) begin
      n_trig++;
      if (q_trig.size() == 0) chk("trig_unexpected_width", tw, 0);
      else chk("trig_width", tw, q_trig.pop_front());
      tw = 0;
    end
  end

  // Press the button until the trigger starts, then wait for the trigger to end
  task automatic press();
    int lat;
    lat = -1;
    btn_r = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (o_trigger === 1'b1) begin
        lat = n;
        break;
      end
    end
    btn_r = 1'b0;
    chk("press_latency_in_range", (lat >= LAT_MIN && lat <= LAT_MAX), 1'b1);
    for (int n = 0; n < 100 && o_trigger === 1'b1; n++) @(negedge clk);
    chk("trig_fall", o_trigger, 1'b0);
  endtask

  // Full ranging cycle with an echo of 'us' microseconds; optional check mid-echo
  task automatic measure(input int us, input int mid_us, input int mid_exp);
    q_trig.push_back(TRIG_CYC);
    press();
    repeat (100) @(negedge clk);
    q_dist.push_back(exp_cm(us));
    echo = 1'b1;
    for (int i = 1; i <= us * CPU; i++) begin
      @(negedge clk);
      if (mid_us != 0 && i == mid_us * CPU) chk("dist_mid_echo", distance, mid_exp);
    end
    echo = 1'b0;
    repeat (6) @(negedge clk);
    last_dist = q_dist.pop_front();
    chk($sformatf("dist_%0dus", us), distance, last_dist);
    repeat (400) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst   = 1'b0;
    btn_r = 1'b0;
    echo  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_trigger", o_trigger, 1'b0);
    chk("rst_distance", distance, 0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_trigger", o_trigger, 1'b0);
    chk("idle_distance", distance, 0);

    // Boundary distances around one centimetre step and saturation
    measure(580, 0, 0);
    measure(579, 0, 0);
    measure(696, 0, 0);
    measure(790, 0, 0);
    measure(57, 0, 0);
    // Over-long echo aborts at ECHO_MAX_US, before the echo falls
    measure(900, 850, DIST_MAX);

    // No echo: timeout back to IDLE, later echo ignored, distance held
    q_trig.push_back(TRIG_CYC);
    press();
    repeat (ECHO_WAIT_US * CPU + 100) @(negedge clk);
    echo = 1'b1;
    repeat (200) @(negedge clk);
    echo = 1'b0;
    repeat (10) @(negedge clk);
    chk("dist_hold_after_timeout", distance, last_dist);
    repeat (400) @(negedge clk);
    measure(116, 0, 0);

    // Press during MEASURE is ignored
    n0 = n_trig;
    q_trig.push_back(TRIG_CYC);
    press();
    repeat (100) @(negedge clk);
    q_dist.push_back(exp_cm(600));
    echo = 1'b1;
    repeat (20) @(negedge clk);
    btn_r = 1'b1;
    repeat (300) @(negedge clk);
    btn_r = 1'b0;
    repeat (600 * CPU - 320) @(negedge clk);
    echo = 1'b0;
    repeat (6) @(negedge clk);
    last_dist = q_dist.pop_front();
    chk("dist_press_in_measure", distance, last_dist);
    repeat (400) @(negedge clk);
    chk("trig_count_press_in_measure", n_trig, n0 + 1);

    // Reset in the middle of MEASURE
    q_trig.push_back(TRIG_CYC);
    press();
    repeat (100) @(negedge clk);
    echo = 1'b1;
    repeat (400) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_distance", distance, 0);
    chk("midrst_trigger", o_trigger, 1'b0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    echo = 1'b0;
    repeat (10) @(negedge clk);
    chk("dist_after_midrst", distance, 0);
    repeat (400) @(negedge clk);
    measure(290, 0, 0);

`ifdef SR04_DEBOUNCE_EN
    // Bounces shorter than the acceptance window produce no trigger
    n0 = n_trig;
    for (int b = 0; b < 5; b++) begin
      btn_r = 1'b1;
      repeat (60) @(negedge clk);
      btn_r = 1'b0;
      repeat (40) @(negedge clk);
    end
    repeat (300) @(negedge clk);
    chk("bounce_no_trigger", n_trig, n0);
`endif

    chk("trig_queue_empty", q_trig.size(), 0);
    chk("dist_queue_empty", q_dist.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
